ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
// - EX->MEM pipeline stage directly downstream of the 64-bit ALU.
// - Captures ALU result, ALU zero flag and the MEM/WB control bundle; resolves beq branch-taken.
// - Presents one entry per cycle to the data-memory stage through a 2-entry skid buffer with valid/ready handshake.
// - Decouples memory back-pressure from the combinational ALU path.
// PARAMETERS
// - DW      64  datapath width (ALU result, store data)
// - RAW     5   register-address width
// PORTS
// - clk            in   1    rising-edge clock
// - rst_n          in   1    synchronous reset, active-low
// - in_valid       in   1    EX offers an entry this cycle
// - in_ready       out  1    stage can accept; registered, equals ~skid_valid
// - in_result      in   DW   ALU result
// - in_flag        in   1    ALU zero flag (SUB result == 0)
// - in_store_data  in   DW   rt contents for stores
// - in_rd          in   RAW  destination register
// - in_ctrl        in   4    {reg_write, mem_read, mem_write, branch}
// - flush          in   1    kill all held entries and the entry offered this cycle
// - out_valid      out  1    main entry valid toward MEM
// - out_ready      in   1    MEM accepts main entry
// - out_result     out  DW   held ALU result (memory address or write-back data)
// - out_store_data out  DW   held store data
// - out_rd         out  RAW  held destination register
// - out_ctrl       out  4    held control bundle
// - out_br_taken   out  1    held branch & flag
// - occupancy      out  2    held entries: 0, 1 or 2
// BEHAVIOUR
// - Storage: main register (drives out_*) plus a skid register; every output is a flop, no combinational in->out path.
// - Reset (rst_n=0 at posedge): both entries invalid; out_valid=0; in_ready=1; occupancy=0.
//   out_result, out_store_data, out_rd, out_ctrl and out_br_taken reset to 0.
// - Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready. Both evaluated at the same posedge.
// - Capture: the branch-taken bit is computed at capture as in_ctrl[0] & in_flag; the entry stores it.
// - State EMPTY (occ 0): accept -> main loaded, go ONE.
// - State ONE (occ 1):
//   - accept & drain -> main reloaded with new entry, stay ONE.
//   - accept & !drain -> new entry to skid, go FULL, in_ready=0 next cycle.
//   - drain only -> EMPTY.
// - State FULL (occ 2): in_ready=0, so no accept is possible. drain -> skid moves to main, skid cleared, go ONE, in_ready=1.
// - Ordering: strict FIFO; the skid entry never bypasses main.
// - Latency: 1 cycle from accept to out_valid when the stage was EMPTY, or when in ONE with a simultaneous drain.
// - Data stability: out_* hold steady while out_valid & !out_ready.
// - Flush (priority over all): next state EMPTY, in_ready=1.
//   - Any same-cycle accept is discarded.
//   - Any same-cycle drain still counts as consumed by MEM.
//   - Data fields may keep stale values; out_ctrl clears to 0.
// - Reset mid-transfer: reset overrides flush and the handshakes.
// - Width rule: in_rd==0 with reg_write=1 is passed through unchanged; the register file ignores x0 writes.
// CONFIGURATION
// - Macro EX_MEM_FWD_EN:
//   - Defined: adds ports fwd_valid (out, 1), fwd_rd (out, RAW) and fwd_data (out, DW).
//   - fwd_valid = out_valid & out_ctrl[3] & ~out_ctrl[2] & (out_rd != 0); fwd_rd = out_rd; fwd_data = out_result.
//   - All three are combinational from main-register flops, for the EX forwarding mux.
//   - Undefined: the ports are absent and there is no forwarding logic.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0.
// - Streaming: out_ready=1, in_result=1..8 on 8 back-to-back cycles -> out_result=1..8 in order, each 1 cycle after accept, occupancy stays 1.
// - Back-pressure: out_ready=0, offer A=0x10 then B=0x20, then C=0x30 held offered.
//   - Required: occupancy=2, in_ready=0, C not taken, out_result=0x10 stable.
//   - Then out_ready=1 -> 0x10, 0x20, 0x30 drain in order.
// - Branch: in_ctrl=4'b0001 with in_flag=1 -> out_br_taken=1; in_flag=0 -> out_br_taken=0; in_ctrl=4'b1000 with in_flag=1 -> out_br_taken=0.
// - Flush: with occupancy=2, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, no entry emerges later.
// - EX_MEM_FWD_EN build:
//   - ALU entry with rd=5, ctrl=4'b1000, result=0xABCD -> fwd_valid=1, fwd_rd=5, fwd_data=0xABCD.
//   - Same with rd=0, or with ctrl=4'b1100 (load) -> fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a 2-entry skid buffer.
//
// The stage captures the ALU result, zero flag, store data, destination
// register and the MEM/WB control bundle. It resolves beq branch-taken at
// capture time. It presents one entry per cycle to the data-memory stage
// through a valid/ready handshake.
//
// Every output is driven directly from a flop, so memory back-pressure
// never reaches the combinational ALU path. The forwarding outputs are the
// only exception: they are simple functions of main-register flops.
//
// Parameters
//   DW   datapath width (ALU result, store data)
//   RAW  register-address width
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   in_valid        EX offers an entry
//   in_ready        stage can accept (registered, low only when both slots are held)
//   in_result       ALU result
//   in_flag         ALU zero flag
//   in_store_data   store data
//   in_rd           destination register
//   in_ctrl         {reg_write, mem_read, mem_write, branch}
//   flush           drop every held entry and the entry offered this cycle
//   out_valid       main entry valid toward MEM
//   out_ready       MEM accepts the main entry
//   out_result      held ALU result
//   out_store_data  held store data
//   out_rd          held destination register
//   out_ctrl        held control bundle
//   out_br_taken    held branch & zero flag
//   occupancy       number of held entries (0..2)
//
// Optional feature, enabled by defining EX_MEM_FWD_EN
//   fwd_valid       main entry is a valid non-load register write to rd != 0
//   fwd_rd          main entry destination register
//   fwd_data        main entry ALU result
module ex_mem_stage #(
   parameter int unsigned DW  = 64,
   parameter int unsigned RAW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_result,
   input  logic           in_flag,
   input  logic [DW-1:0]  in_store_data,
   input  logic [RAW-1:0] in_rd,
   input  logic [3:0]     in_ctrl,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_result,
   output logic [DW-1:0]  out_store_data,
   output logic [RAW-1:0] out_rd,
   output logic [3:0]     out_ctrl,
   output logic           out_br_taken,
`ifdef EX_MEM_FWD_EN
   output logic           fwd_valid,
   output logic [RAW-1:0] fwd_rd,
   output logic [DW-1:0]  fwd_data,
`endif
   output logic [1:0]     occupancy
);

   // The state encoding doubles as the entry count.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DW-1:0]  result;
      logic [DW-1:0]  store_data;
      logic [RAW-1:0] rd;
      logic [3:0]     ctrl;
      logic           br_taken;
   } entry_t;

   state_e     state_q, state_d;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   entry_t     in_entry;
   logic       out_valid_q, out_valid_d;
   logic       in_ready_q, in_ready_d;
   logic [1:0] occ_q, occ_d;
   logic       accept, drain;

   always_comb begin
      in_entry.result     = in_result;
      in_entry.store_data = in_store_data;
      in_entry.rd         = in_rd;
      in_entry.ctrl       = in_ctrl;
      in_entry.br_taken   = in_ctrl[0] & in_flag;
   end

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               main_d  = in_entry;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && drain) begin
               main_d = in_entry;
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = S_FULL;
            end else if (drain) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only a drain can happen.
            if (drain) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      // Flush discards any same-cycle capture. The data fields stay stale,
      // but the control bundle is cleared so no side effect leaks downstream.
      if (flush) begin
         state_d     = S_EMPTY;
         main_d      = main_q;
         main_d.ctrl = '0;
         skid_d      = skid_q;
      end

      out_valid_d = (state_d != S_EMPTY);
      in_ready_d  = (state_d != S_FULL);
      occ_d       = state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_result     = main_q.result;
   assign out_store_data = main_q.store_data;
   assign out_rd         = main_q.rd;
   assign out_ctrl       = main_q.ctrl;
   assign out_br_taken   = main_q.br_taken;
   assign occupancy      = occ_q;

`ifdef EX_MEM_FWD_EN
   // Loads are excluded: their data is not known until after MEM.
   assign fwd_valid = out_valid_q & main_q.ctrl[3] & ~main_q.ctrl[2] & (main_q.rd != '0);
   assign fwd_rd    = main_q.rd;
   assign fwd_data  = main_q.result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   localparam int unsigned DW  = 64;
   localparam int unsigned RAW = 5;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_result;
   logic           in_flag;
   logic [DW-1:0]  in_store_data;
   logic [RAW-1:0] in_rd;
   logic [3:0]     in_ctrl;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_result;
   logic [DW-1:0]  out_store_data;
   logic [RAW-1:0] out_rd;
   logic [3:0]     out_ctrl;
   logic           out_br_taken;
   logic [1:0]     occupancy;
`ifdef EX_MEM_FWD_EN
   logic           fwd_valid;
   logic [RAW-1:0] fwd_rd;
   logic [DW-1:0]  fwd_data;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   ex_mem_stage #(.DW(DW), .RAW(RAW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_result      (in_result),
      .in_flag        (in_flag),
      .in_store_data  (in_store_data),
      .in_rd          (in_rd),
      .in_ctrl        (in_ctrl),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_store_data (out_store_data),
      .out_rd         (out_rd),
      .out_ctrl       (out_ctrl),
      .out_br_taken   (out_br_taken),
`ifdef EX_MEM_FWD_EN
      .fwd_valid      (fwd_valid),
      .fwd_rd         (fwd_rd),
      .fwd_data       (fwd_data),
`endif
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a FIFO of up to two entries plus a few sticky facts.
   typedef struct {
      logic [DW-1:0]  result;
      logic [DW-1:0]  sdata;
      logic [RAW-1:0] rd;
      logic [3:0]     ctrl;
      logic           br;
   } ent_t;

   ent_t        mq[$];
   bit          ctrl_zero;   // no entry loaded since the last reset/flush
   bit          data_zero;   // no entry loaded since the last reset
   logic [DW-1:0] drained[$]; // results consumed by MEM, in order

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] res, input bit flag,
                        input logic [RAW-1:0] rd, input logic [3:0] ctrl);
      in_valid      = v;
      in_result     = res;
      in_flag       = flag;
      in_store_data = ~res;
      in_rd         = rd;
      in_ctrl       = ctrl;
   endtask

   // Advance one clock: update the model from the inputs applied before the
   // edge, then compare every output against it 1 time unit after the edge.
   task automatic tick();
      bit rdy;
      bit acc;
      bit drn;
      ent_t e;
      rdy = (mq.size() < 2);
      if (!rst_n) begin
         mq.delete();
         ctrl_zero = 1;
         data_zero = 1;
      end else begin
         drn = (mq.size() > 0) && out_ready;
         acc = in_valid && rdy && !flush;
         if (drn) drained.push_back(mq.pop_front().result);
         if (flush) begin
            mq.delete();
            ctrl_zero = 1;
         end else if (acc) begin
            e.result = in_result;
            e.sdata  = in_store_data;
            e.rd     = in_rd;
            e.ctrl   = in_ctrl;
            e.br     = in_ctrl[0] & in_flag;
            mq.push_back(e);
            ctrl_zero = 0;
            data_zero = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      if (mq.size() > 0) begin
         chk("out_result", out_result, mq[0].result);
         chk("out_store_data", out_store_data, mq[0].sdata);
         chk("out_rd", 64'(out_rd), 64'(mq[0].rd));
         chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
         chk("out_br_taken", 64'(out_br_taken), 64'(mq[0].br));
      end else begin
         if (ctrl_zero) chk("out_ctrl_cleared", 64'(out_ctrl), 64'd0);
         if (data_zero) begin
            chk("out_result_reset", out_result, 64'd0);
            chk("out_rd_reset", 64'(out_rd), 64'd0);
            chk("out_br_reset", 64'(out_br_taken), 64'd0);
         end
      end
`ifdef EX_MEM_FWD_EN
      if (mq.size() > 0) begin
         chk("fwd_valid", 64'(fwd_valid),
             64'(mq[0].ctrl[3] && !mq[0].ctrl[2] && mq[0].rd != 0));
         chk("fwd_rd", 64'(fwd_rd), 64'(mq[0].rd));
         chk("fwd_data", fwd_data, mq[0].result);
      end else begin
         chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
      end
`endif
   endtask

   initial begin
      int unsigned n0;
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1, 64'h55, 1, 5'd3, 4'b1000);

      // Reset held for two cycles while EX offers an entry.
      tick();
      tick();
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      drive(0, '0, 0, '0, '0);
      tick();

      // Back-to-back streaming with MEM always ready.
      out_ready = 1'b1;
      drained.delete();
      for (int i = 1; i <= 8; i++) begin
         drive(1, 64'(i), 0, 5'(i), 4'b1000);
         tick();
         chk("stream_result", out_result, 64'(i));
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      drive(0, '0, 0, '0, '0);
      tick();
      chk("stream_drained", 64'(drained.size()), 64'd8);

      // Back-pressure: A, B captured, C held offered and refused.
      out_ready = 1'b0;
      drained.delete();
      drive(1, 64'h10, 0, 5'd1, 4'b1000);
      tick();
      drive(1, 64'h20, 0, 5'd2, 4'b1000);
      tick();
      drive(1, 64'h30, 0, 5'd3, 4'b1000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_occ", 64'(occupancy), 64'd2);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_stable", out_result, 64'h10);
      end
      out_ready = 1'b1;
      tick();
      tick();
      drive(0, '0, 0, '0, '0);
      for (int i = 0; i < 3; i++) tick();
      chk("bp_count", 64'(drained.size()), 64'd3);
      if (drained.size() == 3) begin
         chk("bp_order0", drained[0], 64'h10);
         chk("bp_order1", drained[1], 64'h20);
         chk("bp_order2", drained[2], 64'h30);
      end

      // Branch resolution at capture.
      out_ready = 1'b1;
      drive(1, 64'h0, 1, 5'd0, 4'b0001);
      tick();
      chk("br_taken", 64'(out_br_taken), 64'd1);
      drive(1, 64'h7, 0, 5'd0, 4'b0001);
      tick();
      chk("br_not_taken", 64'(out_br_taken), 64'd0);
      drive(1, 64'h0, 1, 5'd4, 4'b1000);
      tick();
      chk("br_no_branch", 64'(out_br_taken), 64'd0);
      drive(0, '0, 0, '0, '0);
      tick();

      // Forwarding cases (checked by the model when the feature is built).
      out_ready = 1'b0;
      drive(1, 64'hABCD, 0, 5'd5, 4'b1000);
      tick();
      out_ready = 1'b1;
      drive(1, 64'hABCD, 0, 5'd0, 4'b1000);
      tick();
      drive(1, 64'hABCD, 0, 5'd5, 4'b1100);
      tick();
      drive(0, '0, 0, '0, '0);
      tick();

      // Flush with both slots held and a new offer present.
      out_ready = 1'b0;
      drive(1, 64'h40, 0, 5'd6, 4'b1010);
      tick();
      drive(1, 64'h41, 0, 5'd7, 4'b1010);
      tick();
      chk("pre_flush_occ", 64'(occupancy), 64'd2);
      drive(1, 64'h42, 0, 5'd8, 4'b1010);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(0, '0, 0, '0, '0);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      drained.delete();
      for (int i = 0; i < 4; i++) tick();
      chk("flush_nothing", 64'(drained.size()), 64'd0);

      // Reset in the middle of a transfer overrides flush and handshakes.
      out_ready = 1'b0;
      drive(1, 64'h50, 1, 5'd9, 4'b1001);
      tick();
      rst_n = 1'b0;
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      flush = 1'b0;
      drive(0, '0, 0, '0, '0);
      tick();

      // Randomized traffic against the model.
      drained.delete();
      n0 = 0;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
               5'($urandom), 4'($urandom));
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         tick();
         if (out_valid) n0++;
      end
      rst_n = 1'b1;
      flush = 1'b0;
      drive(0, '0, 0, '0, '0);
      out_ready = 1'b1;
      tick();
      tick();
      chk("random_activity", 64'(n0 > 0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against an unexpected stall of the stimulus.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
